// File: rtl/sysid_probe_master.sv
// Avalon-MM probe master: reads the slave ID (word 0) and timestamp (word 1),
// compares them against expected values and reports pass/timeout with a done pulse.
module sysid_probe_master #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h4F2B_4A7F,
  parameter int unsigned READ_LATENCY   = 0,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  localparam int unsigned WaitW = 16;
  localparam int unsigned LatW  = 2;
  localparam logic [WaitW-1:0] WaitLimit = WaitW'(TIMEOUT_CYCLES);
  localparam logic [LatW-1:0]  LatLast   = LatW'(READ_LATENCY);
  localparam bit               NoLatency = (READ_LATENCY == 0);

  typedef enum logic [2:0] {
    IDLE, RD_ID, LAT_ID, RD_TS, LAT_TS, CHECK, FIN
  } state_e;

  state_e            state_q, state_d;
  logic              avm_read_q, avm_read_d;
  logic              avm_address_q, avm_address_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic [31:0]       id_q, id_d;
  logic [31:0]       ts_q, ts_d;
  logic [WaitW-1:0]  wait_cnt_q, wait_cnt_d;
  logic [LatW-1:0]   lat_cnt_q, lat_cnt_d;

  logic              in_rd;
  logic [WaitW-1:0]  wait_inc;
  logic              wait_hit;
  logic              lat_last;

  assign in_rd    = (state_q == RD_ID) || (state_q == RD_TS);
  assign wait_inc = wait_cnt_q + WaitW'(1);
  // Stall budget exhausted on this cycle; only meaningful while waitrequest is high.
  assign wait_hit = in_rd && avm_waitrequest && (wait_inc == WaitLimit);
  assign lat_last = (lat_cnt_q == LatLast);

  // State and output registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      avm_read_q    <= 1'b0;
      avm_address_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      timeout_q     <= 1'b0;
      id_q          <= '0;
      ts_q          <= '0;
      wait_cnt_q    <= '0;
      lat_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      avm_read_q    <= avm_read_d;
      avm_address_q <= avm_address_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
      timeout_q     <= timeout_d;
      id_q          <= id_d;
      ts_q          <= ts_d;
      wait_cnt_q    <= wait_cnt_d;
      lat_cnt_q     <= lat_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start) state_d = RD_ID;
      RD_ID:  if (!avm_waitrequest) state_d = NoLatency ? RD_TS : LAT_ID;
              else if (wait_hit)    state_d = FIN;
      LAT_ID: if (lat_last) state_d = RD_TS;
      RD_TS:  if (!avm_waitrequest) state_d = NoLatency ? CHECK : LAT_TS;
              else if (wait_hit)    state_d = FIN;
      LAT_TS: if (lat_last) state_d = CHECK;
      CHECK:  state_d = FIN;
      FIN:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath next values; read strobe tracks the state being entered
  always_comb begin
    avm_read_d    = (state_d == RD_ID) || (state_d == RD_TS);
    avm_address_d = (state_d == RD_TS);
    busy_d        = busy_q;
    done_d        = (state_q == FIN);
    pass_d        = pass_q;
    timeout_d     = timeout_q;
    id_d          = id_q;
    ts_d          = ts_q;
    wait_cnt_d    = wait_cnt_q;
    lat_cnt_d     = lat_cnt_q;
    case (state_q)
      IDLE: if (start) begin
        busy_d    = 1'b1;
        pass_d    = 1'b0;
        timeout_d = 1'b0;
        id_d      = '0;
        ts_d      = '0;
      end
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          lat_cnt_d = LatW'(1);
          if (NoLatency && (state_q == RD_ID)) id_d = avm_readdata;
          if (NoLatency && (state_q == RD_TS)) ts_d = avm_readdata;
        end else begin
          wait_cnt_d = wait_inc;
          if (wait_hit) begin
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end
        end
      end
      LAT_ID: begin
        lat_cnt_d = lat_cnt_q + LatW'(1);
        if (lat_last) id_d = avm_readdata;
      end
      LAT_TS: begin
        lat_cnt_d = lat_cnt_q + LatW'(1);
        if (lat_last) ts_d = avm_readdata;
      end
      CHECK: pass_d = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
      FIN:   busy_d = 1'b0;
      default: ;
    endcase
    if (state_d != state_q) wait_cnt_d = '0;
  end

  assign avm_read    = avm_read_q;
  assign avm_address = avm_address_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign timeout     = timeout_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule

// File: tb/tb_sysid_probe_master.sv
// Scoreboard bench for sysid_probe_master: zero-latency/short-timeout instance (A)
// and a READ_LATENCY=2 instance (B), each with its own slave model.
module tb_sysid_probe_master;

  localparam logic [31:0] GoodTs = 32'h4F2B_4A7F;
  localparam logic [31:0] BadTs  = 32'h4F2B_4A7E;
  localparam int          TmoA   = 4;

  typedef struct {
    logic        pass;
    logic        tmo;
    logic [31:0] id;
    logic [31:0] ts;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        a_start = 1'b0, a_addr, a_read, a_wr, a_busy, a_done, a_pass, a_tmo;
  logic [31:0] a_rdata, a_id, a_ts;
  logic        b_start = 1'b0, b_addr, b_read, b_wr, b_busy, b_done, b_pass, b_tmo;
  logic [31:0] b_rdata, b_id, b_ts;

  sysid_probe_master #(.TIMEOUT_CYCLES(TmoA)) u_dut_a (
    .clock(clock), .reset(reset), .start(a_start),
    .avm_address(a_addr), .avm_read(a_read), .avm_waitrequest(a_wr),
    .avm_readdata(a_rdata), .busy(a_busy), .done(a_done), .pass(a_pass),
    .timeout(a_tmo), .id_value(a_id), .ts_value(a_ts)
  );

  sysid_probe_master #(.READ_LATENCY(2)) u_dut_b (
    .clock(clock), .reset(reset), .start(b_start),
    .avm_address(b_addr), .avm_read(b_read), .avm_waitrequest(b_wr),
    .avm_readdata(b_rdata), .busy(b_busy), .done(b_done), .pass(b_pass),
    .timeout(b_tmo), .id_value(b_id), .ts_value(b_ts)
  );

  // Slave A: zero latency, programmable stall count per read, or stuck waitrequest
  logic [31:0] mem_a [2];
  int          wait_cfg = 0;
  logic        stuck = 1'b0;
  int          wcnt = 0;
  assign a_wr    = stuck || (a_read && (wcnt < wait_cfg));
  assign a_rdata = a_read ? mem_a[a_addr] : 32'h0BAD_0BAD;
  always @(posedge clock) wcnt <= (a_read && a_wr) ? wcnt + 1 : 0;

  // Slave B: data valid only in the second cycle after acceptance
  logic [31:0] mem_b [2];
  logic        p0_v = 1'b0, p1_v = 1'b0, p0_a = 1'b0, p1_a = 1'b0;
  assign b_wr = 1'b0;
  always @(posedge clock) begin
    p0_v <= b_read && !b_wr;
    p0_a <= b_addr;
    p1_v <= p0_v;
    p1_a <= p0_a;
  end
  assign b_rdata = p1_v ? mem_b[p1_a] : 32'hDEAD_BEEF;

  logic sel = 1'b0;
  logic m_read, m_addr, m_wr, m_done, m_pass, m_tmo;
  logic [31:0] m_id, m_ts;
  assign m_read = sel ? b_read : a_read;
  assign m_addr = sel ? b_addr : a_addr;
  assign m_wr   = sel ? b_wr   : a_wr;
  assign m_done = sel ? b_done : a_done;
  assign m_pass = sel ? b_pass : a_pass;
  assign m_tmo  = sel ? b_tmo  : a_tmo;
  assign m_id   = sel ? b_id   : a_id;
  assign m_ts   = sel ? b_ts   : a_ts;

  task automatic drive_start(input logic v);
    if (sel) b_start = v;
    else     a_start = v;
  endtask

  // Pulse start, then watch the bus until done (lat = -1 if it never comes)
  task automatic run_probe(input int restart_at, output int lat, output int rd_cyc,
                           output bit saw1, output bit unstable);
    logic prev_read, prev_addr, prev_wr;
    lat = -1; rd_cyc = 0; saw1 = 0; unstable = 0;
    prev_read = 1'b0; prev_addr = 1'b0; prev_wr = 1'b0;
    drive_start(1'b1);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      drive_start(c == restart_at);
      if (prev_read && prev_wr && (m_read !== 1'b1 || m_addr !== prev_addr)) unstable = 1;
      if (m_read === 1'b1) rd_cyc++;
      if (m_read === 1'b1 && m_addr === 1'b1) saw1 = 1;
      prev_read = m_read; prev_addr = m_addr; prev_wr = m_wr;
      if (m_done === 1'b1) begin
        lat = c;
        break;
      end
    end
    drive_start(1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b1; a_start = 1'b1; b_start = 1'b1;
    repeat (3) @(negedge clock);
    checks++; if ({a_read, a_addr, a_busy, a_done, a_pass, a_tmo} !== 6'b0) begin
      failures++; $display("FAIL reset_ctrl_a: got %b exp 000000", {a_read, a_addr, a_busy, a_done, a_pass, a_tmo});
    end
    checks++; if (a_id !== 32'h0) begin
      failures++; $display("FAIL reset_id: got %h exp 00000000", a_id);
    end
    checks++; if (a_ts !== 32'h0) begin
      failures++; $display("FAIL reset_ts: got %h exp 00000000", a_ts);
    end
    checks++; if ({b_read, b_busy, b_done} !== 3'b0) begin
      failures++; $display("FAIL reset_ctrl_b: got %b exp 000", {b_read, b_busy, b_done});
    end
    a_start = 1'b0; b_start = 1'b0; reset = 1'b0;
    @(negedge clock);
    checks++; if (a_busy !== 1'b0) begin
      failures++; $display("FAIL reset_over_start: busy got %b exp 0", a_busy);
    end
  endtask

  task automatic test_zero_wait();
    exp_t e; int lat, rd; bit s1, un;
    sel = 1'b0; wait_cfg = 0; stuck = 1'b0; mem_a[0] = 32'h0; mem_a[1] = GoodTs;
    sb.push_back('{1'b1, 1'b0, 32'h0, GoodTs, 2 * (0 + 1) + 3});
    run_probe(0, lat, rd, s1, un);
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin
      failures++; $display("FAIL zero_wait_latency: got %0d exp %0d", lat, e.lat);
    end
    checks++; if (m_pass !== e.pass || m_tmo !== e.tmo) begin
      failures++; $display("FAIL zero_wait_status: pass/tmo got %b%b exp %b%b", m_pass, m_tmo, e.pass, e.tmo);
    end
    checks++; if (m_id !== e.id || m_ts !== e.ts) begin
      failures++; $display("FAIL zero_wait_data: got %h/%h exp %h/%h", m_id, m_ts, e.id, e.ts);
    end
    checks++; if (rd != 2) begin
      failures++; $display("FAIL zero_wait_read_cycles: got %0d exp 2", rd);
    end
    @(negedge clock);
    checks++; if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      failures++; $display("FAIL done_single_cycle: done/busy got %b%b exp 00", a_done, a_busy);
    end
  endtask

  task automatic test_bad_ts();
    exp_t e; int lat, rd; bit s1, un;
    sel = 1'b0; wait_cfg = 0; stuck = 1'b0; mem_a[0] = 32'h0; mem_a[1] = BadTs;
    sb.push_back('{1'b0, 1'b0, 32'h0, BadTs, 5});
    run_probe(0, lat, rd, s1, un);
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin
      failures++; $display("FAIL bad_ts_latency: got %0d exp %0d", lat, e.lat);
    end
    checks++; if (m_pass !== e.pass || m_tmo !== e.tmo) begin
      failures++; $display("FAIL bad_ts_status: pass/tmo got %b%b exp %b%b", m_pass, m_tmo, e.pass, e.tmo);
    end
    checks++; if (m_ts !== e.ts) begin
      failures++; $display("FAIL bad_ts_value: got %h exp %h", m_ts, e.ts);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e; int lat, rd; bit s1, un;
    sel = 1'b0; wait_cfg = 0; stuck = 1'b0; mem_a[0] = 32'h0; mem_a[1] = GoodTs;
    for (int k = 0; k < 2; k++) begin
      sb.push_back('{1'b1, 1'b0, 32'h0, GoodTs, 5});
      run_probe(2, lat, rd, s1, un);
      e = sb.pop_front();
      checks++; if (lat != e.lat || m_pass !== e.pass) begin
        failures++; $display("FAIL back_to_back_%0d: lat/pass got %0d/%b exp %0d/%b", k, lat, m_pass, e.lat, e.pass);
      end
    end
    repeat (4) @(negedge clock);
    checks++; if (a_busy !== 1'b0 || a_read !== 1'b0) begin
      failures++; $display("FAIL start_ignored_busy: busy/read got %b%b exp 00", a_busy, a_read);
    end
  endtask

  task automatic test_wait_states();
    exp_t e; int lat, rd; bit s1, un;
    sel = 1'b0; wait_cfg = 3; stuck = 1'b0; mem_a[0] = 32'h0; mem_a[1] = GoodTs;
    sb.push_back('{1'b1, 1'b0, 32'h0, GoodTs, 5 + 2 * 3});
    run_probe(0, lat, rd, s1, un);
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin
      failures++; $display("FAIL wait_latency: got %0d exp %0d", lat, e.lat);
    end
    checks++; if (m_pass !== e.pass || m_ts !== e.ts) begin
      failures++; $display("FAIL wait_result: pass/ts got %b/%h exp %b/%h", m_pass, m_ts, e.pass, e.ts);
    end
    checks++; if (un !== 1'b0 || rd != 8) begin
      failures++; $display("FAIL wait_hold_stable: unstable/read_cycles got %b/%0d exp 0/8", un, rd);
    end
  endtask

  task automatic test_timeout();
    exp_t e; int lat, rd; bit s1, un;
    sel = 1'b0; wait_cfg = 0; stuck = 1'b1; mem_a[0] = 32'h0; mem_a[1] = GoodTs;
    sb.push_back('{1'b0, 1'b1, 32'h0, 32'h0, TmoA + 2});
    run_probe(0, lat, rd, s1, un);
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin
      failures++; $display("FAIL timeout_latency: got %0d exp %0d", lat, e.lat);
    end
    checks++; if (m_pass !== e.pass || m_tmo !== e.tmo) begin
      failures++; $display("FAIL timeout_status: pass/tmo got %b%b exp %b%b", m_pass, m_tmo, e.pass, e.tmo);
    end
    checks++; if (rd != TmoA) begin
      failures++; $display("FAIL timeout_read_cycles: got %0d exp %0d", rd, TmoA);
    end
    checks++; if (s1 !== 1'b0) begin
      failures++; $display("FAIL timeout_no_addr1: saw address-1 read got %b exp 0", s1);
    end
    stuck = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (a_tmo !== 1'b1) begin
      failures++; $display("FAIL timeout_held: got %b exp 1", a_tmo);
    end
  endtask

  task automatic test_latency();
    exp_t e; int lat, rd; bit s1, un;
    logic [31:0] ids [2];
    ids[0] = 32'h0; ids[1] = 32'h0000_1234;
    sel = 1'b1; mem_b[1] = GoodTs;
    for (int k = 0; k < 2; k++) begin
      mem_b[0] = ids[k];
      sb.push_back('{(k == 0), 1'b0, ids[k], GoodTs, 2 * (2 + 1) + 3});
      run_probe(0, lat, rd, s1, un);
      e = sb.pop_front();
      checks++; if (lat != e.lat) begin
        failures++; $display("FAIL latency2_done_%0d: got %0d exp %0d", k, lat, e.lat);
      end
      checks++; if (m_id !== e.id || m_ts !== e.ts) begin
        failures++; $display("FAIL latency2_capture_%0d: got %h/%h exp %h/%h", k, m_id, m_ts, e.id, e.ts);
      end
      checks++; if (m_pass !== e.pass) begin
        failures++; $display("FAIL latency2_pass_%0d: got %b exp %b", k, m_pass, e.pass);
      end
      @(negedge clock);
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    exp_t e; int lat, rd; bit s1, un;
    bit seen_done = 0;
    sel = 1'b0; wait_cfg = 3; stuck = 1'b0; mem_a[0] = 32'h0; mem_a[1] = GoodTs;
    drive_start(1'b1);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      drive_start(1'b0);
    end
    checks++; if (a_read !== 1'b1 || a_addr !== 1'b1) begin
      failures++; $display("FAIL mid_in_rd_ts: read/addr got %b%b exp 11", a_read, a_addr);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (a_read !== 1'b0 || a_busy !== 1'b0) begin
      failures++; $display("FAIL mid_reset_abort: read/busy got %b%b exp 00", a_read, a_busy);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (a_done === 1'b1) seen_done = 1;
    end
    checks++; if (seen_done !== 1'b0) begin
      failures++; $display("FAIL mid_reset_no_done: got %b exp 0", seen_done);
    end
    sb.push_back('{1'b1, 1'b0, 32'h0, GoodTs, 11});
    run_probe(0, lat, rd, s1, un);
    e = sb.pop_front();
    checks++; if (lat != e.lat || m_pass !== e.pass || m_ts !== e.ts) begin
      failures++; $display("FAIL mid_reset_rerun: lat/pass/ts got %0d/%b/%h exp %0d/%b/%h", lat, m_pass, m_ts, e.lat, e.pass, e.ts);
    end
  endtask

  initial begin
    mem_a[0] = 32'h0; mem_a[1] = GoodTs;
    mem_b[0] = 32'h0; mem_b[1] = GoodTs;
    @(negedge clock);
    test_reset();
    test_zero_wait();
    test_bad_ts();
    test_back_to_back();
    test_wait_states();
    test_timeout();
    test_latency();
    test_reset_mid();
    checks++; if (sb.size() != 0) begin
      failures++; $display("FAIL scoreboard_drain: got %0d entries exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
